// File: rtl/fft_onboard_pkg.sv
// rtl/fft_onboard_pkg.sv - shared types, constants and helpers for the FFT on-board self-test
package fft_onboard_pkg;

  localparam int CPLX_W = 12;

  // Galois LFSR feedback mask for x^32+x^22+x^2+x+1 (right-shifting form)
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } cplx_in_t;

  typedef struct packed {
    logic signed [CPLX_W+1:0] re;
    logic signed [CPLX_W+1:0] im;
  } cplx_out_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Rotate left by n (mod 32); upper half of the doubled word is the rotation
  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] d;
    d = {x, x} << n;
    return d[63:32];
  endfunction

endpackage

// File: rtl/fft4_core.sv
// rtl/fft4_core.sv - 4-point forward DFT, exact integer arithmetic, 2-cycle latency
module fft4_core #(
  parameter int DATA_W = 12
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  input  logic [3:0][DATA_W-1:0] i_re,
  input  logic [3:0][DATA_W-1:0] i_im,
  output logic                   o_valid,
  output logic [3:0][DATA_W+1:0] o_re,
  output logic [3:0][DATA_W+1:0] o_im
);

  // Two's complement sign extension by one bit
  function automatic logic [DATA_W:0] sx1(input logic [DATA_W-1:0] v);
    return {v[DATA_W-1], v};
  endfunction

  function automatic logic [DATA_W+1:0] sx2(input logic [DATA_W:0] v);
    return {v[DATA_W], v};
  endfunction

  logic              r_s1_valid;
  logic [DATA_W:0]   r_p02_re, r_p02_im, r_m02_re, r_m02_im;
  logic [DATA_W:0]   r_p13_re, r_p13_im, r_m13_re, r_m13_im;

  // Stage 1: pairwise butterflies x0+-x2 and x1+-x3
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_p02_re   <= '0;
      r_p02_im   <= '0;
      r_m02_re   <= '0;
      r_m02_im   <= '0;
      r_p13_re   <= '0;
      r_p13_im   <= '0;
      r_m13_re   <= '0;
      r_m13_im   <= '0;
    end else begin
      r_s1_valid <= i_valid;
      r_p02_re   <= sx1(i_re[0]) + sx1(i_re[2]);
      r_p02_im   <= sx1(i_im[0]) + sx1(i_im[2]);
      r_m02_re   <= sx1(i_re[0]) - sx1(i_re[2]);
      r_m02_im   <= sx1(i_im[0]) - sx1(i_im[2]);
      r_p13_re   <= sx1(i_re[1]) + sx1(i_re[3]);
      r_p13_im   <= sx1(i_im[1]) + sx1(i_im[3]);
      r_m13_re   <= sx1(i_re[1]) - sx1(i_re[3]);
      r_m13_im   <= sx1(i_im[1]) - sx1(i_im[3]);
    end
  end

  // Stage 2: output bins; -j*(a+jb) = b-ja, so X1/X3 swap re/im of the x1-x3 term
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_re    <= '0;
      o_im    <= '0;
    end else begin
      o_valid <= r_s1_valid;
      o_re[0] <= sx2(r_p02_re) + sx2(r_p13_re);
      o_im[0] <= sx2(r_p02_im) + sx2(r_p13_im);
      o_re[1] <= sx2(r_m02_re) + sx2(r_m13_im);
      o_im[1] <= sx2(r_m02_im) - sx2(r_m13_re);
      o_re[2] <= sx2(r_p02_re) - sx2(r_p13_re);
      o_im[2] <= sx2(r_p02_im) - sx2(r_p13_im);
      o_re[3] <= sx2(r_m02_re) - sx2(r_m13_im);
      o_im[3] <= sx2(r_m02_im) + sx2(r_m13_re);
    end
  end

endmodule

// File: rtl/fft_onboard_top.sv
// rtl/fft_onboard_top.sv - LFSR frame generator, forward DFT core and inverse-DFT checker
module fft_onboard_top
  import fft_onboard_pkg::*;
#(
  parameter int          DATA_W     = 12,
  parameter int          NUM_FRAMES = 1024,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468,
  parameter int          INJECT_ERR = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start_test,
  output logic o_err,
  output logic o_chk_finished
);

  localparam int          CW          = DATA_W + 4;
  localparam logic [15:0] LAST_FRAME  = 16'(NUM_FRAMES - 1);
  localparam logic [15:0] TOTAL_FRAME = 16'(NUM_FRAMES);

  state_t                 r_state, w_next;
  logic                   w_emit;
  logic [31:0]            r_lfsr, w_lfsr_next;
  logic [31:0]            w_rot [4];
  logic [15:0]            r_frame_cnt, r_chk_cnt;
  logic [3:0][DATA_W-1:0] w_x_re, w_x_im;

  logic                   r_gen_valid;
  logic [15:0]            r_gen_idx, r_d1_idx, r_d2_idx;
  logic [3:0][DATA_W-1:0] r_gen_re, r_gen_im, r_d1_re, r_d1_im, r_d2_re, r_d2_im;

  logic                   w_core_valid;
  logic [3:0][DATA_W+1:0] w_core_re, w_core_im, w_chk_re, w_chk_im;

  logic [CW-1:0]          w_c0_re, w_c0_im, w_c1_re, w_c1_im;
  logic [CW-1:0]          w_d0_re, w_d0_im, w_d1_re, w_d1_im;
  logic [CW-1:0]          w_y_re [4];
  logic [CW-1:0]          w_y_im [4];
  logic                   w_mis;

  function automatic logic [CW-1:0] ext_out(input logic [DATA_W+1:0] v);
    return {{2{v[DATA_W+1]}}, v};
  endfunction

  // Four times an input component, at checker width
  function automatic logic [CW-1:0] times4(input logic [DATA_W-1:0] v);
    return {{2{v[DATA_W-1]}}, v, 2'b00};
  endfunction

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state and frame-emit decode
  always_comb begin
    w_next = r_state;
    w_emit = 1'b0;
    case (r_state)
      IDLE:    if (i_start_test) w_next = RUN;
      RUN: begin
        w_emit = 1'b1;
        if (r_frame_cnt == LAST_FRAME) w_next = DRAIN;
      end
      DRAIN:   if (r_chk_cnt == TOTAL_FRAME) w_next = DONE;
      default: w_next = DONE;
    endcase
  end

  // Frame slicing from rotated LFSR words and the next LFSR state
  always_comb begin
    w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_POLY : 32'h0);
    for (int k = 0; k < 4; k++) begin
      w_rot[k]  = rotl32(r_lfsr, 5'(8 * k));
      w_x_re[k] = DATA_W'(w_rot[k]);
      w_x_im[k] = DATA_W'(w_rot[k] >> 16);
    end
  end

  // Generator: one frame per RUN cycle, LFSR steps with each emitted frame
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lfsr      <= LFSR_SEED;
      r_frame_cnt <= '0;
      r_gen_valid <= 1'b0;
      r_gen_idx   <= '0;
      r_gen_re    <= '0;
      r_gen_im    <= '0;
    end else begin
      r_gen_valid <= w_emit;
      if (w_emit) begin
        r_lfsr      <= w_lfsr_next;
        r_frame_cnt <= r_frame_cnt + 16'd1;
        r_gen_idx   <= r_frame_cnt;
        r_gen_re    <= w_x_re;
        r_gen_im    <= w_x_im;
      end
    end
  end

  fft4_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (r_gen_valid),
    .i_re    (r_gen_re),
    .i_im    (r_gen_im),
    .o_valid (w_core_valid),
    .o_re    (w_core_re),
    .o_im    (w_core_im)
  );

  // Delay line matching the core latency so reference and result line up
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_d1_re  <= '0;
      r_d1_im  <= '0;
      r_d1_idx <= '0;
      r_d2_re  <= '0;
      r_d2_im  <= '0;
      r_d2_idx <= '0;
    end else begin
      r_d1_re  <= r_gen_re;
      r_d1_im  <= r_gen_im;
      r_d1_idx <= r_gen_idx;
      r_d2_re  <= r_d1_re;
      r_d2_im  <= r_d1_im;
      r_d2_idx <= r_d1_idx;
    end
  end

  // Inverse DFT (conjugate twiddles) of the core output and compare with 4*x
  always_comb begin
    w_chk_re = w_core_re;
    w_chk_im = w_core_im;
    if ((INJECT_ERR != 0) && (r_d2_idx == 16'd3)) w_chk_re[0][0] = ~w_core_re[0][0];
    w_c0_re = ext_out(w_chk_re[0]) + ext_out(w_chk_re[2]);
    w_c0_im = ext_out(w_chk_im[0]) + ext_out(w_chk_im[2]);
    w_c1_re = ext_out(w_chk_re[0]) - ext_out(w_chk_re[2]);
    w_c1_im = ext_out(w_chk_im[0]) - ext_out(w_chk_im[2]);
    w_d0_re = ext_out(w_chk_re[1]) + ext_out(w_chk_re[3]);
    w_d0_im = ext_out(w_chk_im[1]) + ext_out(w_chk_im[3]);
    w_d1_re = ext_out(w_chk_re[1]) - ext_out(w_chk_re[3]);
    w_d1_im = ext_out(w_chk_im[1]) - ext_out(w_chk_im[3]);
    w_y_re[0] = w_c0_re + w_d0_re;
    w_y_im[0] = w_c0_im + w_d0_im;
    w_y_re[1] = w_c1_re - w_d1_im;
    w_y_im[1] = w_c1_im + w_d1_re;
    w_y_re[2] = w_c0_re - w_d0_re;
    w_y_im[2] = w_c0_im - w_d0_im;
    w_y_re[3] = w_c1_re + w_d1_im;
    w_y_im[3] = w_c1_im - w_d1_re;
    w_mis = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (w_y_re[k] != times4(r_d2_re[k]) || w_y_im[k] != times4(r_d2_im[k])) w_mis = 1'b1;
    end
  end

  // Registered compare: sticky error and checked-frame count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_err     <= 1'b0;
      r_chk_cnt <= '0;
    end else if (w_core_valid) begin
      r_chk_cnt <= r_chk_cnt + 16'd1;
      if (w_mis) o_err <= 1'b1;
    end
  end

  // Sticky finished flag raised on entry to DONE
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)               o_chk_finished <= 1'b0;
    else if (w_next == DONE) o_chk_finished <= 1'b1;
  end

endmodule

// File: tb/tb_fft_onboard_top.sv
// tb/tb_fft_onboard_top.sv - directed self-checking bench for fft_onboard_top and fft4_core
module tb_fft_onboard_top;
  import fft_onboard_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, err, fin;
  logic rst_i, start_i, err_i, fin_i;

  logic             c_vin, c_vout;
  logic [3:0][11:0] c_re, c_im;
  logic [3:0][13:0] c_ore, c_oim;

  int n_cmp = 0;
  int n_mis = 0;
  int xr[4], xi[4], er[4], ei[4];
  int lat, err_lat, bad;

  fft_onboard_top dut (
    .i_clk(clk), .i_rst(rst), .i_start_test(start), .o_err(err), .o_chk_finished(fin)
  );

  fft_onboard_top #(.NUM_FRAMES(16), .INJECT_ERR(1)) dut_inj (
    .i_clk(clk), .i_rst(rst_i), .i_start_test(start_i), .o_err(err_i), .o_chk_finished(fin_i)
  );

  fft4_core #(.DATA_W(12)) core (
    .i_clk(clk), .i_rst(rst), .i_valid(c_vin), .i_re(c_re), .i_im(c_im),
    .o_valid(c_vout), .o_re(c_ore), .o_im(c_oim)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_after(input int n);
    logic [31:0] s;
    s = 32'hACE1_2468;
    for (int i = 0; i < n; i++) s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    return s;
  endfunction

  task automatic core_run(input string tag);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      c_re[k] = 12'(xr[k]);
      c_im[k] = 12'(xi[k]);
    end
    c_vin = 1'b1;
    @(posedge clk); #1;
    c_vin = 1'b0;
    chk({tag, "_valid_c1"}, c_vout, 0);
    @(posedge clk); #1;
    chk({tag, "_valid_c2"}, c_vout, 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_X%0d_re", tag, k), $signed(c_ore[k]), er[k]);
      chk($sformatf("%s_X%0d_im", tag, k), $signed(c_oim[k]), ei[k]);
    end
  endtask

  task automatic run_measure(input string tag, output int l);
    @(posedge clk); #1;
    l = 0;
    while (!fin && l < 3000) begin
      @(posedge clk); #1;
      l++;
      if (l == 1) begin
        chk({tag, "_gen_x0_re"}, dut.r_gen_re[0], 12'h468);
        chk({tag, "_gen_x0_im"}, dut.r_gen_im[0], 12'hCE1);
        chk({tag, "_gen_x1_re"}, dut.r_gen_re[1], 12'h8AC);
        chk({tag, "_gen_x1_im"}, dut.r_gen_im[1], 12'h124);
      end
      if (l == 500) chk({tag, "_lfsr_500"}, dut.r_lfsr, lfsr_after(500));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rst_i = 1'b1; start_i = 1'b0;
    c_vin = 1'b0; c_re = '0; c_im = '0;
    #50;
    chk("rst_err", err, 0);
    chk("rst_fin", fin, 0);
    chk("rst_state", longint'(dut.r_state), longint'(IDLE));
    chk("rst_lfsr", dut.r_lfsr, 32'hACE1_2468);
    chk("rst_inj_err", err_i, 0);
    #50;
    rst = 1'b0; rst_i = 1'b0;

    // Core directed vectors while the top sits idle
    xr = '{1, 0, 0, 0};      xi = '{0, 0, 0, 0};
    er = '{1, 1, 1, 1};      ei = '{0, 0, 0, 0};
    core_run("impulse");
    xr = '{5, 5, 5, 5};      er = '{20, 0, 0, 0};
    core_run("const");
    xr = '{7, -7, 7, -7};    er = '{0, 0, 28, 0};
    core_run("alt");
    xr = '{-2048, -2048, -2048, -2048}; xi = '{-2048, -2048, -2048, -2048};
    er = '{-8192, 0, 0, 0};  ei = '{-8192, 0, 0, 0};
    core_run("extreme");
    xr = '{0, 1, 0, 0};      xi = '{0, 0, 0, 0};
    er = '{1, 0, -1, 0};     ei = '{0, -1, 0, 1};
    core_run("x1_twiddle");

    // Nominal run: start at 200 ns
    wait ($time >= 200);
    start = 1'b1;
    run_measure("nom", lat);
    chk("nom_fin_latency", lat, 1028);
    chk("nom_err", err, 0);
    bad = 0;
    repeat (10000) begin
      @(posedge clk); #1;
      if (fin !== 1'b1 || err !== 1'b0) bad++;
    end
    chk("nom_stable", bad, 0);

    // Reset after DONE, start held high across release
    @(negedge clk); rst = 1'b1; #1;
    chk("rst_done_fin", fin, 0);
    @(negedge clk); rst = 1'b0;
    run_measure("held", lat);
    chk("held_fin_latency", lat, 1028);
    chk("held_err", err, 0);

    // Reset mid-run after 500 frames
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 500; i++) begin @(posedge clk); #1; end
    chk("mid_lfsr_500", dut.r_lfsr, lfsr_after(500));
    #3 rst = 1'b1; start = 1'b0; #1;
    chk("mid_err", err, 0);
    chk("mid_fin", fin, 0);
    chk("mid_state", longint'(dut.r_state), longint'(IDLE));
    chk("mid_lfsr", dut.r_lfsr, 32'hACE1_2468);
    chk("mid_frame_cnt", dut.r_frame_cnt, 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("idle_no_start", longint'(dut.r_state), longint'(IDLE));
    @(negedge clk); start = 1'b1;
    run_measure("restart", lat);
    chk("restart_fin_latency", lat, 1028);
    chk("restart_err", err, 0);

    // Error injection instance
    @(negedge clk); start_i = 1'b1;
    @(posedge clk); #1;
    lat = 0; err_lat = -1;
    while (!fin_i && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (err_i && err_lat < 0) err_lat = lat;
    end
    chk("inj_err_latency", err_lat, 7);
    chk("inj_fin_latency", lat, 20);
    chk("inj_err_final", err_i, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
